hazard_ctrl: RTL and testbench

Parametrised pipeline-control unit for the 5-stage LEGv8 pipelined processor; successor to the single load-use `data_hazard` enable.
- Generates per-stage register enables and bubble/flush strobes for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Handles three events: load-use stalls of configurable length, taken-branch flushes, and multi-cycle data-memory waits.
- Sits beside the datapath; consumes register addresses and control bits already present in the pipeline registers.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/sat_counter.sv | 22 ++
 rtl/hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared types and constants for the pipeline hazard controller.
//   state_t    : controller states (run, load-use stall, data-memory wait)
//   CNT_W      : width of the internal stall/wait down-counters
//   ZR_IDX_DEF : default index of the zero register (XZR)
package hazard_pkg;

    localparam int CNT_W      = 4;
    localparam int ZR_IDX_DEF = 31;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter -- free-running event counter that sticks at all-ones.
//   clk   : clock, rising edge
//   clr_n : synchronous active-low clear
//   en    : count this cycle
//   q     : current count
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!clr_n)
            q <= '0;
        else if (en && (q != {W{1'b1}}))
            q <= q + W'(1);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- LEGv8 5-stage pipeline control: per-stage register enables
// and bubble/flush strobes for load-use stalls, taken-branch flushes and
// multi-cycle data-memory waits.
//   CLOCK_50, reset (sync active-low)
//   id_*        : source registers / read flags of the ID instruction
//   ex_*        : EX instruction valid, load flag and destination
//   mem_access  : MEM instruction reads or writes data memory
//   branch_taken: branch resolved taken in MEM
//   *_en, *_flush: pipeline register controls (combinational)
//   stall_count, flush_count: performance counters
// Optional macro HAZARD_PERF_EN: when defined, stall_count/flush_count are
// live saturating counters; otherwise both are tied to zero.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int RA_W     = 5,
    parameter int ZR_IDX   = ZR_IDX_DEF,
    parameter int LU_STALL = 1,
    parameter int MEM_LAT  = 0
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic [RA_W-1:0] id_rn,
    input  logic [RA_W-1:0] id_rm,
    input  logic            id_uses_rn,
    input  logic            id_uses_rm,
    input  logic            ex_valid,
    input  logic            ex_memRead,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            mem_access,
    input  logic            branch_taken,
    output logic            pc_en,
    output logic            if_id_en,
    output logic            id_ex_en,
    output logic            ex_mem_en,
    output logic            mem_wb_en,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            ex_mem_flush,
    output logic [31:0]     stall_count,
    output logic [31:0]     flush_count
);

    localparam logic [CNT_W-1:0] LU_INIT = CNT_W'(LU_STALL - 1);
    localparam logic [CNT_W-1:0] MW_INIT = CNT_W'(MEM_LAT);
    localparam logic [RA_W-1:0]  ZR      = RA_W'(ZR_IDX);
    localparam logic             WAIT_ON = (MEM_LAT > 0);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] lu_cnt, lu_cnt_nxt;
    logic [CNT_W-1:0] mw_cnt, mw_cnt_nxt;
    logic             ret_lu, ret_lu_nxt;   // wait interrupted a load-use stall
    logic             done_flag, done_nxt;  // MEM instruction already waited
    logic             mw_rel;
    logic             lu, mem_trig;

    assign lu = ex_valid & ex_memRead & (ex_rd != ZR) &
                ((id_uses_rn & (id_rn == ex_rd)) | (id_uses_rm & (id_rm == ex_rd)));

    assign mem_trig = WAIT_ON & mem_access & ~done_flag & (state != ST_MEM_WAIT);

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state     <= ST_RUN;
            lu_cnt    <= '0;
            mw_cnt    <= '0;
            ret_lu    <= 1'b0;
            done_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            lu_cnt    <= lu_cnt_nxt;
            mw_cnt    <= mw_cnt_nxt;
            ret_lu    <= ret_lu_nxt;
            done_flag <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lu_cnt_nxt   = lu_cnt;
        mw_cnt_nxt   = mw_cnt;
        ret_lu_nxt   = ret_lu;
        mw_rel       = 1'b0;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;

        case (state)
            ST_MEM_WAIT: begin
                {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
                if (mw_cnt <= CNT_W'(1)) begin
                    // Release: resume an interrupted load-use stall if any.
                    state_nxt  = ret_lu ? ST_LU_STALL : ST_RUN;
                    ret_lu_nxt = 1'b0;
                    mw_cnt_nxt = '0;
                    mw_rel     = 1'b1;
                end else begin
                    mw_cnt_nxt = mw_cnt - CNT_W'(1);
                end
            end
            ST_RUN, ST_LU_STALL: begin
                if (mem_trig) begin
                    // Freeze everything; lu_cnt is kept for the resume.
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
                    state_nxt  = ST_MEM_WAIT;
                    mw_cnt_nxt = MW_INIT;
                    ret_lu_nxt = (state == ST_LU_STALL);
                end else if (branch_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    state_nxt    = ST_RUN;
                    lu_cnt_nxt   = '0;
                end else if (state == ST_LU_STALL) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    if (lu_cnt <= CNT_W'(1)) begin
                        state_nxt  = ST_RUN;
                        lu_cnt_nxt = '0;
                    end else begin
                        lu_cnt_nxt = lu_cnt - CNT_W'(1);
                    end
                end else if (lu) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    if (LU_STALL > 1) begin
                        state_nxt  = ST_LU_STALL;
                        lu_cnt_nxt = LU_INIT;
                    end
                end
            end
            default: state_nxt = ST_RUN;
        endcase

        // The waited instruction leaves MEM on the first advancing cycle.
        done_nxt = mw_rel | (done_flag & ~mem_wb_en);

        if (!reset) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
            {if_id_flush, id_ex_flush, ex_mem_flush}          = '1;
        end
    end

`ifdef HAZARD_PERF_EN
    sat_counter #(.W(32)) u_stall_cnt (
        .clk   (CLOCK_50),
        .clr_n (reset),
        .en    (reset & ~pc_en),
        .q     (stall_count)
    );

    // ex_mem_flush is raised outside reset only when a branch is acted on.
    sat_counter #(.W(32)) u_flush_cnt (
        .clk   (CLOCK_50),
        .clr_n (reset),
        .en    (reset & ex_mem_flush),
        .q     (flush_count)
    );
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic       reset, id_uses_rn, id_uses_rm, ex_valid, ex_memRead, mem_access, branch_taken;
    logic [4:0] id_rn, id_rm, ex_rd;
    wire  [7:0] o_a, o_b;   // {pc,if_id,id_ex,ex_mem,mem_wb en, if_id,id_ex,ex_mem flush}
    wire  [31:0] sc_a, fc_a, sc_b, fc_b;

    hazard_ctrl #(.LU_STALL(1), .MEM_LAT(0)) dut_a (
        .CLOCK_50(CLOCK_50), .reset(reset), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_valid(ex_valid),
        .ex_memRead(ex_memRead), .ex_rd(ex_rd), .mem_access(mem_access),
        .branch_taken(branch_taken), .pc_en(o_a[7]), .if_id_en(o_a[6]),
        .id_ex_en(o_a[5]), .ex_mem_en(o_a[4]), .mem_wb_en(o_a[3]),
        .if_id_flush(o_a[2]), .id_ex_flush(o_a[1]), .ex_mem_flush(o_a[0]),
        .stall_count(sc_a), .flush_count(fc_a));

    hazard_ctrl #(.LU_STALL(3), .MEM_LAT(2)) dut_b (
        .CLOCK_50(CLOCK_50), .reset(reset), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .ex_valid(ex_valid),
        .ex_memRead(ex_memRead), .ex_rd(ex_rd), .mem_access(mem_access),
        .branch_taken(branch_taken), .pc_en(o_b[7]), .if_id_en(o_b[6]),
        .id_ex_en(o_b[5]), .ex_mem_en(o_b[4]), .mem_wb_en(o_b[3]),
        .if_id_flush(o_b[2]), .id_ex_flush(o_b[1]), .ex_mem_flush(o_b[0]),
        .stall_count(sc_b), .flush_count(fc_b));

    // Reference model: pending stall cycles / wait cycles as plain integers.
    int  lul [2] = '{1, 3};
    int  mlat[2] = '{0, 2};
    int  stall_left[2], wait_left[2];
    bit  done[2], known[2];
    longint exp_sc[2], exp_fc[2];
    int  checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string name, input bit r, input bit mem, input bit br,
                        input bit exv, input bit exmr, input int exrd,
                        input int rn, input int rm, input bit urn, input bit urm);
        @(negedge CLOCK_50);
        reset = r; mem_access = mem; branch_taken = br;
        ex_valid = exv; ex_memRead = exmr; ex_rd = 5'(exrd);
        id_rn = 5'(rn); id_rm = 5'(rm); id_uses_rn = urn; id_uses_rm = urm;
        #1;
        for (int d = 0; d < 2; d++) begin
            bit lu, trig;
            logic [7:0] e;
            lu   = exv && exmr && (exrd != 31) && ((urn && rn == exrd) || (urm && rm == exrd));
            trig = (mlat[d] > 0) && mem && !done[d];
            if (!r)                              e = 8'b0000_0111;
            else if (wait_left[d] > 0 || trig)   e = 8'b0000_0000;
            else if (br)                         e = 8'b1111_1111;
            else if (stall_left[d] > 0 || lu)    e = 8'b0011_1010;
            else                                 e = 8'b1111_1000;

            chk($sformatf("%s/%0d/ctl", name, d), {24'd0, (d == 0) ? o_a : o_b}, {24'd0, e});
            if (known[d]) begin
`ifdef HAZARD_PERF_EN
                chk($sformatf("%s/%0d/stall_cnt", name, d), (d == 0) ? sc_a : sc_b, 32'(exp_sc[d]));
                chk($sformatf("%s/%0d/flush_cnt", name, d), (d == 0) ? fc_a : fc_b, 32'(exp_fc[d]));
`else
                chk($sformatf("%s/%0d/stall_cnt", name, d), (d == 0) ? sc_a : sc_b, 32'd0);
                chk($sformatf("%s/%0d/flush_cnt", name, d), (d == 0) ? fc_a : fc_b, 32'd0);
`endif
            end

            if (!r) begin
                stall_left[d] = 0; wait_left[d] = 0; done[d] = 0;
                exp_sc[d] = 0; exp_fc[d] = 0; known[d] = 1;
            end else begin
                if (!e[7]) exp_sc[d]++;
                if (wait_left[d] > 0) begin
                    wait_left[d]--;
                    if (wait_left[d] == 0) done[d] = 1;
                end else if (trig) begin
                    wait_left[d] = mlat[d];
                end else begin
                    if (br) begin
                        stall_left[d] = 0;
                        exp_fc[d]++;
                    end else if (stall_left[d] > 0) stall_left[d]--;
                    else if (lu) stall_left[d] = lul[d] - 1;
                    done[d] = 0;
                end
            end
        end
    endtask

    function automatic int pick();
        int v = $urandom_range(0, 4);
        return (v == 4) ? 31 : v;
    endfunction

    initial begin
        // name      r  mem br exv exmr exrd rn rm urn urm
        step("rst",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst",   0, 1, 1, 1, 1, 1, 1, 1, 1, 1);
        step("idle",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // load-use on X1, then let the stall drain
        step("lu",    1, 0, 0, 1, 1, 1, 1, 0, 1, 0);
        repeat (4) step("lu_drain", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("lu_rm", 1, 0, 0, 1, 1, 2, 0, 2, 0, 1);
        repeat (3) step("lu_drain", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("zr",    1, 0, 0, 1, 1, 31, 31, 0, 1, 0);
        step("novld", 1, 0, 0, 0, 1, 1, 1, 0, 1, 0);
        step("noload",1, 0, 0, 1, 0, 1, 1, 0, 1, 0);
        // branch in the second stall cycle aborts the stall
        step("lu",    1, 0, 0, 1, 1, 1, 1, 0, 1, 0);
        step("lu_br", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step("post_br", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // held memory access: trigger + 2 waits, one free cycle, re-trigger
        repeat (6) step("mem_hold", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // branch held during wait is only acted on at release
        step("mw",    1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step("mw_br", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step("idle",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // wait interrupting a load-use stall, then resume
        step("lu",    1, 0, 0, 1, 1, 3, 3, 0, 1, 0);
        step("lu_mw", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) step("resume", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // reset in the middle of a wait
        step("mw",    1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("mw",    1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("mw_rst",0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("after", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("lu",    1, 0, 0, 1, 1, 1, 1, 0, 1, 0);
        repeat (4) step("cnt", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 2000; i++) begin
            step("rand", ($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 12), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 1), pick(), pick(), pick(),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
